// File: rtl/int_arbiter.sv
// Interrupt arbiter: rising-edge capture of peripheral interrupt lines, fixed
// lowest-index priority, and a claim/complete handshake over a 4-word register map.
module int_arbiter #(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic [7:0]         int_flag_o
);

  localparam logic [1:0] REG_ENABLE   = 2'd0;
  localparam logic [1:0] REG_PENDING  = 2'd1;
  localparam logic [1:0] REG_CLAIM    = 2'd2;
  localparam logic [1:0] REG_COMPLETE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SERVICE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [3:0]         claim_id_q, claim_id_d;
  logic [31:0]        data_q, data_d;
  logic [7:0]         int_flag_q, int_flag_d;

  logic [NUM_SRC-1:0] masked;
  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] w1c_clr;
  logic [NUM_SRC-1:0] claim_clr;
  logic               win_found;
  logic [2:0]         win_idx;
  logic [3:0]         win_id;
  logic [7:0]         win_onehot;
  logic [1:0]         reg_sel;
  logic               claim_rd;
  logic               complete_wr;
  logic               unused_ok;

  assign unused_ok = ^{addr_i, data_i};

  assign reg_sel     = addr_i[3:2];
  assign claim_rd    = re_i && (reg_sel == REG_CLAIM);
  assign complete_wr = we_i && (reg_sel == REG_COMPLETE) && (data_i[3:0] == claim_id_q);
  assign src_rise    = src_i & ~src_prev_q;
  assign src_prev_d  = src_i;

  always_comb begin
    masked    = pending_q & enable_q;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (masked[i] && !win_found) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
    win_id     = win_found ? (4'(win_idx) + 4'd1) : '0;
    win_onehot = 8'b1 << win_idx;
  end

  always_comb begin
    state_d    = state_q;
    int_flag_d = '0;
    claim_id_d = claim_id_q;
    claim_clr  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_ASSERT;
          int_flag_d = win_onehot;
        end
      end
      ST_ASSERT: begin
        if (!win_found) begin
          state_d = ST_IDLE;
        end else if (claim_rd) begin
          state_d    = ST_SERVICE;
          claim_id_d = win_id;
          claim_clr  = NUM_SRC'(1'b1) << win_idx;
        end else begin
          int_flag_d = win_onehot;
        end
      end
      ST_SERVICE: begin
        if (complete_wr) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clears are applied before sets so a same-cycle edge keeps the bit pending.
  always_comb begin
    w1c_clr   = (we_i && (reg_sel == REG_PENDING)) ? data_i[NUM_SRC-1:0] : '0;
    pending_d = (pending_q & ~(w1c_clr | claim_clr)) | src_rise;
    enable_d  = (we_i && (reg_sel == REG_ENABLE)) ? data_i[NUM_SRC-1:0] : enable_q;
  end

  always_comb begin
    data_d = '0;
    if (re_i) begin
      unique case (reg_sel)
        REG_ENABLE:  data_d = 32'(enable_q);
        REG_PENDING: data_d = 32'(pending_q);
        REG_CLAIM:   data_d = (state_q == ST_ASSERT) ? 32'(win_id) : '0;
        default:     data_d = '0;
      endcase
    end
  end

  // Edge history reloads from the live lines during reset so sources held
  // high across reset do not register a fresh edge afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      enable_q   <= '0;
      pending_q  <= '0;
      src_prev_q <= src_i;
      claim_id_q <= '0;
      data_q     <= '0;
      int_flag_q <= '0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      src_prev_q <= src_prev_d;
      claim_id_q <= claim_id_d;
      data_q     <= data_d;
      int_flag_q <= int_flag_d;
    end
  end

  assign data_o     = data_q;
  assign int_flag_o = int_flag_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the register map and arbitration rules.
module tb_int_arbiter;

  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk;
  logic         rst;
  logic [N-1:0] src;
  logic         we;
  logic         re;
  logic [31:0]  addr;
  logic [31:0]  data;
  logic [31:0]  data_o;
  logic [7:0]   int_flag_o;

  int checks   = 0;
  int failures = 0;

  int m_en, m_pend, m_prev, m_claim, m_data, m_flag;
  bit m_asrt, m_svc;

  int_arbiter #(.NUM_SRC(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_i      (src),
    .we_i       (we),
    .re_i       (re),
    .addr_i     (addr),
    .data_i     (data),
    .data_o     (data_o),
    .int_flag_o (int_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int lo, id, sel, rdata, nx_pend, nflag;
    if (!rst) begin
      m_en = 0; m_pend = 0; m_prev = int'(src); m_claim = 0;
      m_data = 0; m_flag = 0; m_asrt = 0; m_svc = 0;
      return;
    end
    lo = -1;
    for (int i = 0; i < N; i++) begin
      if (((m_pend & m_en) >> i) & 1) begin
        lo = i;
        break;
      end
    end
    id  = lo + 1;
    sel = int'(addr[3:2]);
    rdata = 0;
    if (re) begin
      case (sel)
        0: rdata = m_en;
        1: rdata = m_pend;
        2: rdata = m_asrt ? id : 0;
        default: rdata = 0;
      endcase
    end
    nx_pend = m_pend;
    nflag   = 0;
    if (m_asrt) begin
      if (id == 0) m_asrt = 0;
      else if (re && sel == 2) begin
        m_asrt  = 0;
        m_svc   = 1;
        m_claim = id;
        nx_pend = nx_pend & ~(1 << lo);
      end else nflag = 1 << lo;
    end else if (m_svc) begin
      if (we && sel == 3 && int'(data[3:0]) == m_claim) m_svc = 0;
    end else if (id != 0) begin
      m_asrt = 1;
      nflag  = 1 << lo;
    end
    if (we && sel == 1) nx_pend = nx_pend & ~(int'(data) & MASK);
    nx_pend = nx_pend | (int'(src) & ~m_prev & MASK);
    if (we && sel == 0) m_en = int'(data) & MASK;
    m_pend = nx_pend;
    m_prev = int'(src);
    m_data = rdata;
    m_flag = nflag;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("data_o", data_o, 32'(m_data));
    check("int_flag_o", 32'(int_flag_o), 32'(m_flag));
  endtask

  task automatic op(input bit r, input logic [N-1:0] s, input bit w, input bit rd,
                    input logic [31:0] a, input logic [31:0] d);
    rst = r; src = s; we = w; re = rd; addr = a; data = d;
    tick();
  endtask

  initial begin
    rst = 1'b0; src = '0; we = 1'b0; re = 1'b0; addr = '0; data = '0;
    @(negedge clk);
    op(0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0);
    check("reset_data", data_o, 32'h0);
    check("reset_flag", 32'(int_flag_o), 32'h0);

    // single source: flag, claim ID, pending cleared
    op(1, 0, 1, 0, 32'h0, 32'hF);
    op(1, 4'b0100, 0, 0, 0, 0);
    op(1, 4'b0000, 0, 0, 0, 0);
    check("s1_flag", 32'(int_flag_o), 32'h04);
    op(1, 0, 0, 1, 32'h8, 0);
    check("s1_claim", data_o, 32'd3);
    check("s1_flag_off", 32'(int_flag_o), 32'h0);
    op(1, 0, 0, 1, 32'h4, 0);
    check("s1_pending", data_o, 32'h0);
    op(1, 0, 1, 0, 32'hC, 32'd3);

    // simultaneous sources: priority then second grant
    op(1, 4'b1010, 0, 0, 0, 0);
    op(1, 4'b0000, 0, 0, 0, 0);
    check("s2_flag", 32'(int_flag_o), 32'h02);
    op(1, 0, 0, 1, 32'h8, 0);
    check("s2_claim1", data_o, 32'd2);
    op(1, 0, 1, 0, 32'hC, 32'd2);
    op(1, 0, 0, 0, 0, 0);
    check("s2_flag2", 32'(int_flag_o), 32'h08);
    op(1, 0, 0, 1, 32'h8, 0);
    check("s2_claim2", data_o, 32'd4);
    op(1, 0, 1, 0, 32'hC, 32'd4);

    // mismatched COMPLETE is ignored
    op(1, 4'b0001, 0, 0, 0, 0);
    op(1, 4'b0000, 0, 0, 0, 0);
    op(1, 0, 0, 1, 32'h8, 0);
    check("s3_claim", data_o, 32'd1);
    op(1, 4'b0100, 1, 0, 32'hC, 32'd3);
    op(1, 4'b0000, 0, 1, 32'h8, 0);
    check("s3_still_svc", data_o, 32'd0);
    check("s3_flag", 32'(int_flag_o), 32'h0);
    op(1, 0, 1, 0, 32'hC, 32'd1);
    op(1, 0, 0, 0, 0, 0);
    check("s3_idle_flag", 32'(int_flag_o), 32'h04);
    op(1, 0, 0, 1, 32'h8, 0);
    op(1, 0, 1, 0, 32'hC, 32'd3);

    // disabled source stays pending, then enable
    op(1, 0, 1, 0, 32'h0, 32'h0);
    op(1, 4'b0001, 0, 0, 0, 0);
    op(1, 4'b0000, 0, 0, 0, 0);
    op(1, 0, 0, 1, 32'h4, 0);
    check("s4_pending", data_o, 32'h1);
    check("s4_flag", 32'(int_flag_o), 32'h0);
    op(1, 0, 1, 0, 32'h0, 32'h1);
    op(1, 0, 0, 0, 0, 0);
    check("s4_flag_on", 32'(int_flag_o), 32'h01);

    // reset in ASSERT with a source held high
    op(0, 4'b0010, 0, 0, 0, 0);
    check("s5_data", data_o, 32'h0);
    check("s5_flag", 32'(int_flag_o), 32'h0);
    op(1, 4'b0010, 0, 1, 32'h0, 0);
    check("s5_enable", data_o, 32'h0);
    op(1, 4'b0010, 0, 1, 32'h8, 0);
    check("s5_claim", data_o, 32'h0);
    op(1, 4'b0010, 0, 1, 32'h4, 0);
    check("s5_no_repend", data_o, 32'h0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] d;
      rst  = ($urandom_range(0, 249) != 0);
      src  = src ^ N'($urandom & $urandom & MASK);
      we   = ($urandom_range(0, 3) == 0);
      re   = ($urandom_range(0, 1) == 0);
      addr = $urandom;
      d    = $urandom;
      if ($urandom_range(0, 1) == 0) d[3:0] = 4'(m_claim);
      data = d;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
